// File: rtl/ic_pp.sv
// ic_pp: ping-pong input cache feeding one systolic-array column.
// Two banks of DEPTH words alternate: the writer fills one bank while the
// column drains the other. Frames may be shorter than DEPTH (wlast), and a
// bank may be replayed for data reuse.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   din, wr_en, wlast : write data, write strobe, last word of frame
//   wrdy              : write bank is free (combinational)
//   rrdy              : read bank holds a complete frame (combinational)
//   rd_en_pre, replay : read strobe from previous column, keep bank on last read
//   rd_en_nxt         : rd_en_pre delayed one cycle for the next column
//   col_data_in/valid : registered read data to the column
//   empty             : both banks free and no partial frame (combinational)
//   err               : sticky protocol-violation flag
module ic_pp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  wlast,
  output logic                  wrdy,
  output logic                  rrdy,
  input  logic                  rd_en_pre,
  input  logic                  replay,
  output logic                  rd_en_nxt,
  output logic [DATA_WIDTH-1:0] col_data_in,
  output logic                  col_valid_in,
  output logic                  empty,
  output logic                  err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  logic [1:0]            bank_full_q, bank_full_d;
  logic [LW-1:0]         len_q [2];
  logic [LW-1:0]         len_d [2];
  logic                  wsel_q, wsel_d;
  logic                  rsel_q, rsel_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic [AW-1:0]         raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] col_data_q, col_data_d;
  logic                  col_valid_q, col_valid_d;
  logic                  rd_en_nxt_q;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  logic wr_acc, wr_end, rd_acc, rd_end;

  // Accept/terminate conditions for both ports
  assign wr_acc = wr_en & ~bank_full_q[wsel_q];
  assign wr_end = wlast | (waddr_q == AW'(DEPTH - 1));
  assign rd_acc = rd_en_pre & bank_full_q[rsel_q];
  assign rd_end = (LW'(raddr_q) == (len_q[rsel_q] - LW'(1)));

  // Next-state logic; write and read never touch the same bank, so the
  // set and clear of bank_full may both apply in one cycle.
  always_comb begin
    bank_full_d = bank_full_q;
    len_d       = len_q;
    wsel_d      = wsel_q;
    rsel_d      = rsel_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    col_data_d  = '0;
    col_valid_d = 1'b0;
    err_d       = err_q;

    if (wr_acc) begin
      if (wr_end) begin
        len_d[wsel_q]       = LW'(waddr_q) + LW'(1);
        bank_full_d[wsel_q] = 1'b1;
        waddr_d             = '0;
        wsel_d              = ~wsel_q;
      end else begin
        waddr_d = waddr_q + AW'(1);
      end
    end
    if (wr_en & ~wr_acc) err_d = 1'b1;

    if (rd_acc) begin
      col_data_d  = mem_q[rsel_q][raddr_q];
      col_valid_d = 1'b1;
      if (rd_end) begin
        raddr_d = '0;
        if (!replay) begin
          bank_full_d[rsel_q] = 1'b0;
          rsel_d              = ~rsel_q;
        end
      end else begin
        raddr_d = raddr_q + AW'(1);
      end
    end
    if (rd_en_pre & ~rd_acc) err_d = 1'b1;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_q <= '0;
      len_q       <= '{default: '0};
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      col_data_q  <= '0;
      col_valid_q <= 1'b0;
      rd_en_nxt_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      len_q       <= len_d;
      wsel_q      <= wsel_d;
      rsel_q      <= rsel_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      col_data_q  <= col_data_d;
      col_valid_q <= col_valid_d;
      rd_en_nxt_q <= rd_en_pre;
      err_q       <= err_d;
    end
  end

  // Bank storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wsel_q][waddr_q] <= din;
  end

  assign wrdy         = ~bank_full_q[wsel_q];
  assign rrdy         = bank_full_q[rsel_q];
  assign empty        = ~bank_full_q[0] & ~bank_full_q[1] & (waddr_q == '0);
  assign rd_en_nxt    = rd_en_nxt_q;
  assign col_data_in  = col_data_q;
  assign col_valid_in = col_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ic_pp.sv
// tb_ic_pp: directed scenarios plus randomized traffic for ic_pp, checked
// every cycle against a frame-level model built from queues.
module tb_ic_pp;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, wr_en, wlast, rd_en_pre, replay;
  logic [DW-1:0] din;
  logic          wrdy, rrdy, rd_en_nxt, col_valid_in, empty, err;
  logic [DW-1:0] col_data_in;

  always #5 clk = ~clk;

  ic_pp #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .wlast(wlast),
    .wrdy(wrdy), .rrdy(rrdy), .rd_en_pre(rd_en_pre), .replay(replay),
    .rd_en_nxt(rd_en_nxt), .col_data_in(col_data_in),
    .col_valid_in(col_valid_in), .empty(empty), .err(err)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: each bank is a stored frame with a length; the
  // writer's partial frame is a queue.
  logic [DW-1:0] m_mem [2][DEPTH];
  int            m_len [2];
  bit            m_full [2];
  int            m_wsel, m_rsel, m_rpos;
  logic [DW-1:0] m_cur [$];
  logic [DW-1:0] e_data;
  bit            e_valid, e_nxt, e_err;

  always @(posedge clk) begin
    bit wok, rok;
    if (rst) begin
      m_full[0] = 0; m_full[1] = 0;
      m_wsel = 0; m_rsel = 0; m_rpos = 0;
      m_cur.delete();
      e_valid = 0; e_data = '0; e_nxt = 0; e_err = 0;
    end else begin
      wok   = !m_full[m_wsel];
      rok   = m_full[m_rsel];
      e_nxt = rd_en_pre;
      if (rd_en_pre && rok) begin
        e_valid = 1;
        e_data  = m_mem[m_rsel][m_rpos];
        if (m_rpos == m_len[m_rsel] - 1) begin
          m_rpos = 0;
          if (!replay) begin
            m_full[m_rsel] = 0;
            m_rsel ^= 1;
          end
        end else m_rpos++;
      end else begin
        e_valid = 0;
        e_data  = '0;
      end
      if (rd_en_pre && !rok) e_err = 1;
      if (wr_en) begin
        if (!wok) e_err = 1;
        else begin
          m_cur.push_back(din);
          if (wlast || m_cur.size() == DEPTH) begin
            foreach (m_cur[i]) m_mem[m_wsel][i] = m_cur[i];
            m_len[m_wsel]  = m_cur.size();
            m_full[m_wsel] = 1;
            m_cur.delete();
            m_wsel ^= 1;
          end
        end
      end
    end
  end

  // Observed output words with their cycle stamps
  logic [DW-1:0] obs [$];
  int            obs_t [$];
  int            cyc = 0;

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("wrdy", 32'(wrdy), 32'(!m_full[m_wsel]));
      check("rrdy", 32'(rrdy), 32'(m_full[m_rsel]));
      check("empty", 32'(empty), 32'(!m_full[0] && !m_full[1] && m_cur.size() == 0));
      check("col_valid", 32'(col_valid_in), 32'(e_valid));
      check("col_data", 32'(col_data_in), 32'(e_data));
      check("rd_en_nxt", 32'(rd_en_nxt), 32'(e_nxt));
      check("err", 32'(err), 32'(e_err));
      if (col_valid_in === 1'b1) begin
        obs.push_back(col_data_in);
        obs_t.push_back(cyc);
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic wl,
                      input logic [DW-1:0] d, input logic rd, input logic rp);
    rst = r; wr_en = w; wlast = wl; din = d; rd_en_pre = rd; replay = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0);
  endtask

  task automatic check_obs(input string name, input logic [DW-1:0] exp [$]);
    check({name, "_count"}, 32'(obs.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      check(name, 32'(obs[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [DW-1:0] exp [$];

    // 1: full-depth frame after reset
    step(1, 0, 0, '0, 0, 0);
    chk_en = 1'b1;
    check("t1_reset_wrdy", 32'(wrdy), 32'd1);
    check("t1_reset_empty", 32'(empty), 32'd1);
    check("t1_reset_valid", 32'(col_valid_in), 32'd0);
    obs.delete(); obs_t.delete();
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0, DW'(i + 1), 0, 0);
      if (i == DEPTH - 2) check("t1_rrdy_before", 32'(rrdy), 32'd0);
    end
    check("t1_rrdy_after", 32'(rrdy), 32'd1);
    check("t1_wrdy_after", 32'(wrdy), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, '0, 1, 0);
    idle(2);
    exp.delete();
    for (int i = 0; i < DEPTH; i++) exp.push_back(DW'(i + 1));
    check_obs("t1_data", exp);

    // 2: short frame terminated by wlast
    obs.delete(); obs_t.delete();
    step(0, 1, 0, 8'hA0, 0, 0);
    step(0, 1, 0, 8'hA1, 0, 0);
    step(0, 1, 1, 8'hA2, 0, 0);
    check("t2_rrdy", 32'(rrdy), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1, 0);
    check("t2_rrdy_done", 32'(rrdy), 32'd0);
    check("t2_empty_done", 32'(empty), 32'd1);
    idle(2);
    exp = '{8'hA0, 8'hA1, 8'hA2};
    check_obs("t2_data", exp);

    // 3: ping-pong; B completes on the same edge A's last word is read
    obs.delete(); obs_t.delete();
    for (int i = 0; i < 4; i++) step(0, 1, (i == 3), DW'(8'h30 + i), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, (i == 3), DW'(8'h40 + i), 1, 0);
    check("t3_swap_rrdy", 32'(rrdy), 32'd1);
    check("t3_swap_wrdy", 32'(wrdy), 32'd1);
    check("t3_swap_empty", 32'(empty), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, 0);
    idle(2);
    exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43};
    check_obs("t3_data", exp);
    if (obs_t.size() == 8) check("t3_no_gap", 32'(obs_t[7] - obs_t[0]), 32'd7);
    else check("t3_no_gap_count", 32'(obs_t.size()), 32'd8);

    // 4: replay
    obs.delete(); obs_t.delete();
    step(0, 1, 0, 8'h11, 0, 0);
    step(0, 1, 1, 8'h22, 0, 0);
    step(0, 0, 0, '0, 1, 0);
    step(0, 0, 0, '0, 1, 1);
    check("t4_kept", 32'(rrdy), 32'd1);
    step(0, 0, 0, '0, 1, 0);
    step(0, 0, 0, '0, 1, 0);
    check("t4_freed", 32'(rrdy), 32'd0);
    idle(2);
    exp = '{8'h11, 8'h22, 8'h11, 8'h22};
    check_obs("t4_data", exp);

    // 5: overflow then underflow
    step(0, 1, 1, 8'h55, 0, 0);
    step(0, 1, 1, 8'h66, 0, 0);
    check("t5_full_wrdy", 32'(wrdy), 32'd0);
    check("t5_err_clean", 32'(err), 32'd0);
    step(0, 1, 0, 8'h77, 0, 0);
    check("t5_overflow_err", 32'(err), 32'd1);
    step(1, 0, 0, '0, 0, 0);
    check("t5_reset_err", 32'(err), 32'd0);
    step(0, 0, 0, '0, 1, 0);
    check("t5_underflow_valid", 32'(col_valid_in), 32'd0);
    check("t5_underflow_err", 32'(err), 32'd1);

    // 6: reset mid-frame discards the partial frame
    step(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, DW'(8'h80 + i), 0, 0);
    check("t6_partial_empty", 32'(empty), 32'd0);
    step(1, 0, 0, '0, 0, 0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_wrdy", 32'(wrdy), 32'd1);
    obs.delete(); obs_t.delete();
    step(0, 1, 0, 8'h90, 0, 0);
    step(0, 1, 1, 8'h91, 0, 0);
    step(0, 0, 0, '0, 1, 0);
    step(0, 0, 0, '0, 1, 0);
    idle(2);
    exp = '{8'h90, 8'h91};
    check_obs("t6_data", exp);

    // Randomized traffic, occasional resets
    step(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 4) == 0),
           DW'($urandom),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0));
    end
    idle(3);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
